// File: rtl/mode_sequencer.sv
// mode_sequencer: debounced button mode stepper with a blank/latch/settle modeline sequence; define MODESEQ_AUTOREPEAT_EN for hold-to-repeat
module mode_sequencer #(
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLANK_CYCLES    = 256,
  parameter int SETTLE_CYCLES   = 256,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic              sys_clk,
  input  logic              act_reset,
  input  logic              but_center,
  output logic [MODE_W-1:0] mode_sel,
  output logic              mline_latch,
  output logic              vid_reset,
  output logic              busy
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SQ_W = $clog2((BLANK_CYCLES > SETTLE_CYCLES ? BLANK_CYCLES : SETTLE_CYCLES) + 1);
  if (2**MODE_W < NUM_MODES || DEBOUNCE_CYCLES < 1 || BLANK_CYCLES < 1 || SETTLE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("mode_sequencer: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, BLANK, LATCH, SETTLE} state_t;
  state_t state;
  logic sync_a, btn_s, btn_db, btn_db_q, press, advance;
  logic [DB_W-1:0] cnt;
  logic [SQ_W-1:0] seq_cnt;
  always_ff @(posedge sys_clk) begin
    if (act_reset) begin
      sync_a   <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_a   <= but_center;
      btn_s    <= sync_a;
      btn_db_q <= btn_db;
      if (btn_s == btn_db)
        cnt <= '0;
      else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        cnt    <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
  always_comb press = btn_db & ~btn_db_q;
`ifdef MODESEQ_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  logic [RP_W-1:0] rep_cnt;
  logic rep_hit;
  always_comb rep_hit = (state == IDLE) && btn_db && (rep_cnt == RP_W'(REPEAT_CYCLES - 1));
  always_ff @(posedge sys_clk) begin
    if (act_reset || state != IDLE || !btn_db || rep_hit)
      rep_cnt <= '0;
    else
      rep_cnt <= rep_cnt + 1'b1;
  end
  always_comb advance = press | rep_hit;
`else
  always_comb advance = press;
`endif
  // Outputs are registered alongside the state so they change on the same edge as the transition.
  always_ff @(posedge sys_clk) begin
    if (act_reset) begin
      state       <= BLANK;
      seq_cnt     <= '0;
      mode_sel    <= '0;
      mline_latch <= 1'b0;
      vid_reset   <= 1'b1;
      busy        <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (advance) begin
            mode_sel  <= (mode_sel == MODE_W'(NUM_MODES - 1)) ? '0 : mode_sel + 1'b1;
            state     <= BLANK;
            seq_cnt   <= '0;
            vid_reset <= 1'b1;
            busy      <= 1'b1;
          end
        BLANK:
          if (seq_cnt == SQ_W'(BLANK_CYCLES - 1)) begin
            state       <= LATCH;
            seq_cnt     <= '0;
            mline_latch <= 1'b1;
          end else
            seq_cnt <= seq_cnt + 1'b1;
        LATCH: begin
          state       <= SETTLE;
          mline_latch <= 1'b0;
        end
        SETTLE:
          if (seq_cnt == SQ_W'(SETTLE_CYCLES - 1)) begin
            state     <= IDLE;
            seq_cnt   <= '0;
            vid_reset <= 1'b0;
            busy      <= 1'b0;
          end else
            seq_cnt <= seq_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: randomized and directed button stimulus checked every cycle against a timeline model; honours MODESEQ_AUTOREPEAT_EN
module tb_mode_sequencer;
  localparam int N = 4, MW = 2, D = 8, B = 4, S = 4, R = 32, MAXE = 32768;
  logic sys_clk = 1'b0, act_reset = 1'b1, but_center = 1'b0;
  logic [MW-1:0] mode_sel;
  logic mline_latch, vid_reset, busy;
  always #5 sys_clk = ~sys_clk;
  mode_sequencer #(
    .NUM_MODES(N), .MODE_W(MW), .DEBOUNCE_CYCLES(D),
    .BLANK_CYCLES(B), .SETTLE_CYCLES(S), .REPEAT_CYCLES(R)
  ) dut (
    .sys_clk(sys_clk), .act_reset(act_reset), .but_center(but_center),
    .mode_sel(mode_sel), .mline_latch(mline_latch), .vid_reset(vid_reset), .busy(busy)
  );
  int n_chk = 0, n_pass = 0;
  bit hist[MAXE];
  int e = 0, r = 0, e0 = 0, run = 0, m_mode = 0, n_latch = 0, chg = -1, fh = 0;
  bit db = 1'b0, db_prev = 1'b0;
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, e);
  endtask
  // Synchronised level seen by the debouncer just before edge x: the pin as sampled two edges earlier.
  function automatic bit bs(int x);
    return (x - 2 > r) ? hist[x - 2] : 1'b0;
  endfunction
  task automatic model_edge(bit b, bit rst);
    bit press, idle, rep, tog;
    hist[e] = b;
    if (rst) begin
      r = e; e0 = e; db = 1'b0; db_prev = 1'b0; m_mode = 0; run = 0;
      return;
    end
    press = db & ~db_prev;
    idle = (e - e0) >= B + S + 2;
`ifdef MODESEQ_AUTOREPEAT_EN
    run = (idle && db) ? run + 1 : 0;
    rep = idle && db && (run % R == 0);
`else
    rep = 1'b0;
`endif
    if (idle && (press || rep)) begin
      m_mode = (m_mode + 1) % N;
      e0 = e;
    end
    tog = 1'b1;
    for (int j = 0; j < D; j++) if (bs(e - j) == db) tog = 1'b0;
    db_prev = db;
    if (tog) db = ~db;
  endtask
  task automatic tick(bit b, bit rst);
    int k;
    but_center = b;
    act_reset = rst;
    @(posedge sys_clk);
    model_edge(b, rst);
    #1;
    k = e - e0;
    check("mode_sel", mode_sel, m_mode);
    check("vid_reset", vid_reset, k <= B + S);
    check("busy", busy, k <= B + S);
    check("mline_latch", mline_latch, k == B);
    e++;
  endtask
  task automatic hold(bit b, int n);
    logic [MW-1:0] pm;
    for (int i = 0; i < n; i++) begin
      pm = mode_sel;
      tick(b, 1'b0);
      if (mline_latch) n_latch++;
      if (mode_sel != pm && chg < 0) chg = e - 1;
    end
  endtask
  initial begin
    tick(1'b0, 1'b1);
    n_latch = 0;
    hold(1'b0, 12);
    check("reset_seq_latches", n_latch, 1);
    fh = e; chg = -1; n_latch = 0;
    hold(1'b1, 20);
    hold(1'b0, 30);
    check("press_latency", chg - fh + 1, D + 3);
    check("press_latches", n_latch, 1);
    check("press_mode", mode_sel, 1);
    n_latch = 0;
    hold(1'b1, 1); hold(1'b0, 12);
    hold(1'b1, 3); hold(1'b0, 12);
    hold(1'b1, 7); hold(1'b0, 12);
    check("glitch_latches", n_latch, 0);
    check("glitch_mode", mode_sel, 1);
    n_latch = 0;
    for (int p = 0; p < 4; p++) begin
      hold(1'b1, 12);
      hold(1'b0, 20);
      check("wrap_mode", mode_sel, (2 + p) % N);
    end
    check("wrap_latches", n_latch, 4);
    hold(1'b1, 11);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 30);
    check("settle_press_dropped", mode_sel, 2);
    for (int p = 0; p < 8 && mode_sel != 1; p++) begin
      hold(1'b1, 12);
      hold(1'b0, 20);
    end
    hold(1'b1, 11);
    check("pre_reset_mode", mode_sel, 2);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("mid_reset_mode", mode_sel, 0);
    check("mid_reset_vid", vid_reset, 1);
    n_latch = 0;
    hold(1'b0, 15);
    check("mid_reset_latches", n_latch, 1);
    hold(1'b1, 100);
    hold(1'b0, 20);
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 40));
      hold(1'b0, $urandom_range(1, 30));
      if ($urandom_range(0, 40) == 0) tick(1'b0, 1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
